// File: rtl/jd_sequencer.sv
// jd PMOD output sequencer: queues core-side writes in a small FIFO and holds
// each byte on jd_o for HOLD_CYCLES cycles, pulsing strobe_o once per byte.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | nothing on display; jd_o keeps the last byte shown
// ST_HOLD | a byte is on jd_o; cnt_q counts the remaining hold cycles
module jd_sequencer #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 5,
  parameter logic [7:0]  IDLE_VALUE  = 8'h00
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_i,
  input  logic [7:0]             wr_data_i,
  input  logic                   clr_overflow_i,
  output logic [7:0]             jd_o,
  output logic                   strobe_o,
  output logic                   busy_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o
);

  localparam int unsigned   PW       = $clog2(DEPTH);
  localparam int unsigned   LW       = PW + 1;
  localparam int unsigned   CW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e          state_q,  state_d;
  logic [CW-1:0]   cnt_q,    cnt_d;
  logic [7:0]      jd_q,     jd_d;
  logic            strobe_q, strobe_d;
  logic            ovf_q,    ovf_d;
  logic [LW-1:0]   count_q,  count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];
  logic            push;
  logic            pop;
  logic            full;

  // full is taken from the registered count, so a same-cycle pop never
  // makes room for a write that arrives while the FIFO is full.
  assign full = (count_q == LVL_FULL);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    jd_d     = jd_q;
    strobe_d = 1'b0;
    ovf_d    = ovf_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    push     = wr_i && !full;
    pop      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (count_q != '0) begin
          pop = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      jd_d     = mem_q[rd_ptr_q];
      strobe_d = 1'b1;
      cnt_d    = CNT_LOAD;
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    if (push) begin
      mem_d[wr_ptr_q] = wr_data_i;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase

    // a drop in the same cycle as a clear leaves the flag set
    if (clr_overflow_i) ovf_d = 1'b0;
    if (wr_i && full)   ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      jd_q     <= IDLE_VALUE;
      strobe_q <= 1'b0;
      ovf_q    <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      jd_q     <= jd_d;
      strobe_q <= strobe_d;
      ovf_q    <= ovf_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign jd_o       = jd_q;
  assign strobe_o   = strobe_q;
  assign overflow_o = ovf_q;
  assign level_o    = count_q;
  assign full_o     = full;
  assign busy_o     = (state_q == ST_HOLD) || (count_q != '0);

endmodule

// File: tb/tb_jd_sequencer.sv
// Bench for jd_sequencer: two instances (HOLD_CYCLES 5 and 1), directed
// timing scenarios, then random traffic against a queue-based reference.
module tb_jd_sequencer;

  localparam int D = 4;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b1, wr0 = 1'b0, clr0 = 1'b0;
  logic [7:0] wd0 = 8'h00;
  logic [7:0] jd0;
  logic       strobe0, busy0, full0, ovf0;
  logic [2:0] level0;

  logic       rst1 = 1'b1, wr1 = 1'b0, clr1 = 1'b0;
  logic [7:0] wd1 = 8'h00;
  logic [7:0] jd1;
  logic       strobe1, busy1, full1, ovf1;
  logic [2:0] level1;

  jd_sequencer #(.DEPTH(4), .HOLD_CYCLES(5), .IDLE_VALUE(8'h00)) u_dut0 (
    .clk_i(clk), .rst_i(rst0), .wr_i(wr0), .wr_data_i(wd0),
    .clr_overflow_i(clr0), .jd_o(jd0), .strobe_o(strobe0), .busy_o(busy0),
    .full_o(full0), .level_o(level0), .overflow_o(ovf0));

  jd_sequencer #(.DEPTH(4), .HOLD_CYCLES(1), .IDLE_VALUE(8'h00)) u_dut1 (
    .clk_i(clk), .rst_i(rst1), .wr_i(wr1), .wr_data_i(wd1),
    .clr_overflow_i(clr1), .jd_o(jd1), .strobe_o(strobe1), .busy_o(busy1),
    .full_o(full1), .level_o(level1), .overflow_o(ovf1));

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queued bytes plus the number of cycles the current
  // byte still has on the pins (0 = nothing being shown).
  logic [7:0] mq [2][$];
  logic [7:0] sb [2][$];
  int         remain [2] = '{0, 0};
  logic [7:0] m_jd   [2] = '{8'h00, 8'h00};
  bit         m_str  [2] = '{1'b0, 1'b0};
  bit         m_ovf  [2] = '{1'b0, 1'b0};

  function automatic int hold_of(input int k);
    return (k == 0) ? 5 : 1;
  endfunction

  task automatic model_step(input int k, input logic rst, input logic wr,
                            input logic [7:0] d, input logic clr);
    bit was_full;
    if (rst) begin
      mq[k].delete();
      sb[k].delete();
      remain[k] = 0;
      m_jd[k]   = 8'h00;
      m_str[k]  = 1'b0;
      m_ovf[k]  = 1'b0;
      return;
    end
    was_full = (mq[k].size() == D);
    m_str[k] = 1'b0;
    if (remain[k] <= 1) begin
      if (mq[k].size() > 0) begin
        m_jd[k]   = mq[k].pop_front();
        remain[k] = hold_of(k);
        m_str[k]  = 1'b1;
      end else begin
        remain[k] = 0;
      end
    end else begin
      remain[k]--;
    end
    if (wr && !was_full) begin
      mq[k].push_back(d);
      sb[k].push_back(d);
    end
    if (clr) m_ovf[k] = 1'b0;
    if (wr && was_full) m_ovf[k] = 1'b1;
  endtask

  always @(posedge clk) begin
    model_step(0, rst0, wr0, wd0, clr0);
    model_step(1, rst1, wr1, wd1, clr1);
  end

  task automatic check_k(input int k, input logic [7:0] jd, input logic st,
                         input logic bz, input logic fl, input logic [2:0] lv,
                         input logic ov);
    string p;
    logic [7:0] e;
    p = $sformatf("u%0d", k);
    chk({p, "_jd"},     32'(jd), 32'(m_jd[k]));
    chk({p, "_strobe"}, 32'(st), 32'(m_str[k]));
    chk({p, "_level"},  32'(lv), 32'(mq[k].size()));
    chk({p, "_full"},   32'(fl), 32'(mq[k].size() == D));
    chk({p, "_busy"},   32'(bz), 32'((remain[k] > 0) || (mq[k].size() > 0)));
    chk({p, "_ovf"},    32'(ov), 32'(m_ovf[k]));
    if (st === 1'b1) begin
      if (sb[k].size() == 0) begin
        chk({p, "_sb_unexpected_strobe"}, 32'(1), 32'(0));
      end else begin
        e = sb[k].pop_front();
        chk({p, "_sb_byte"}, 32'(jd), 32'(e));
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check_k(0, jd0, strobe0, busy0, full0, level0, ovf0);
      check_k(1, jd1, strobe1, busy1, full1, level1, ovf1);
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    wr0 = 1'b0; clr0 = 1'b0; rst0 = 1'b0;
    wr1 = 1'b0; clr1 = 1'b0; rst1 = 1'b0;
    for (int i = 0; i < n; i++) next_cyc();
  endtask

  logic [7:0] t6_data [3] = '{8'hAA, 8'hBB, 8'hCC};
  logic [7:0] got [$];

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int peak;
    int nstr;
    int dens0;
    int dens1;

    next_cyc();
    mon_en = 1'b1;
    next_cyc();
    idle(2);

    // single byte
    for (int t = 0; t < 9; t++) begin
      wr0 = (t == 0); wd0 = 8'hA5;
      @(negedge clk);
      if (t == 2) begin
        chk("single_jd_c2", 32'(jd0), 32'hA5);
        chk("single_strobe_c2", 32'(strobe0), 32'd1);
      end
      if (t >= 3 && t <= 6) chk("single_strobe_low", 32'(strobe0), 32'd0);
      if (t >= 7) begin
        chk("single_busy_low", 32'(busy0), 32'd0);
        chk("single_jd_kept", 32'(jd0), 32'hA5);
      end
      next_cyc();
    end
    idle(3);

    // four-byte burst
    peak = 0; nstr = 0;
    for (int t = 0; t < 24; t++) begin
      wr0 = (t < 4); wd0 = 8'(t + 1);
      @(negedge clk);
      if (int'(level0) > peak) peak = int'(level0);
      if (strobe0) nstr++;
      if (t == 2 || t == 7 || t == 12 || t == 17) begin
        chk("burst_jd", 32'(jd0), 32'((t - 2) / 5 + 1));
        chk("burst_strobe", 32'(strobe0), 32'd1);
      end
      if (t == 21) chk("burst_busy_c21", 32'(busy0), 32'd1);
      if (t == 22) chk("burst_busy_c22", 32'(busy0), 32'd0);
      next_cyc();
    end
    chk("burst_peak_level", 32'(peak), 32'd3);
    chk("burst_strobe_count", 32'(nstr), 32'd4);

    // overflow: six writes into a four-deep FIFO
    got.delete();
    for (int t = 0; t < 32; t++) begin
      wr0 = (t < 6); wd0 = 8'(8'h10 + t);
      @(negedge clk);
      if (strobe0) got.push_back(jd0);
      if (t == 5) chk("ovf_full_c5", 32'(full0), 32'd1);
      if (t == 5) chk("ovf_flag_c5", 32'(ovf0), 32'd0);
      if (t == 6) chk("ovf_flag_c6", 32'(ovf0), 32'd1);
      next_cyc();
    end
    chk("ovf_out_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      chk("ovf_out_byte", 32'(got[i]), 32'(8'h10 + i));

    // clear alone
    for (int t = 0; t < 2; t++) begin
      clr0 = (t == 0); wr0 = 1'b0;
      @(negedge clk);
      if (t == 1) chk("clr_alone", 32'(ovf0), 32'd0);
      next_cyc();
    end

    // clear together with a dropped write: set wins
    for (int t = 0; t < 32; t++) begin
      wr0 = (t < 6); wd0 = 8'(8'h20 + t); clr0 = (t == 5);
      @(negedge clk);
      if (t == 5) chk("clr_drop_full", 32'(full0), 32'd1);
      if (t == 6) chk("clr_drop_set_wins", 32'(ovf0), 32'd1);
      next_cyc();
    end
    clr0 = 1'b1; next_cyc(); clr0 = 1'b0;
    idle(2);

    // reset in the middle of a burst
    for (int t = 0; t < 15; t++) begin
      wr0 = (t < 4) || (t == 11);
      wd0 = (t < 4) ? 8'(t + 1) : 8'h3C;
      rst0 = (t == 9);
      @(negedge clk);
      if (t == 10) begin
        chk("rst_jd", 32'(jd0), 32'h00);
        chk("rst_level", 32'(level0), 32'd0);
        chk("rst_strobe", 32'(strobe0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_ovf", 32'(ovf0), 32'd0);
      end
      if (t == 13) begin
        chk("post_rst_jd", 32'(jd0), 32'h3C);
        chk("post_rst_strobe", 32'(strobe0), 32'd1);
      end
      next_cyc();
    end
    idle(10);

    // HOLD_CYCLES = 1 instance
    for (int t = 0; t < 7; t++) begin
      wr1 = (t < 3); wd1 = t6_data[t % 3];
      @(negedge clk);
      if (t >= 2 && t <= 4) begin
        chk("h1_jd", 32'(jd1), 32'(t6_data[t - 2]));
        chk("h1_strobe", 32'(strobe1), 32'd1);
      end
      if (t >= 5) begin
        chk("h1_busy_low", 32'(busy1), 32'd0);
        chk("h1_strobe_low", 32'(strobe1), 32'd0);
      end
      next_cyc();
    end
    idle(3);

    // random traffic, checked every cycle by the monitor
    dens0 = 5; dens1 = 5;
    for (int c = 0; c < 1500; c++) begin
      if (c % 64 == 0) begin
        dens0 = $urandom_range(1, 10);
        dens1 = $urandom_range(1, 10);
      end
      wr0  = ($urandom_range(0, 9) < dens0);
      wd0  = 8'($urandom);
      clr0 = ($urandom_range(0, 19) == 0);
      rst0 = ($urandom_range(0, 299) == 0);
      wr1  = ($urandom_range(0, 9) < dens1);
      wd1  = 8'($urandom);
      clr1 = ($urandom_range(0, 19) == 0);
      rst1 = ($urandom_range(0, 299) == 0);
      next_cyc();
    end

    idle(40);
    @(negedge clk);
    chk("drain_sb0_empty", 32'(sb[0].size()), 32'd0);
    chk("drain_sb1_empty", 32'(sb[1].size()), 32'd0);
    chk("drain_busy0", 32'(busy0), 32'd0);
    chk("drain_busy1", 32'(busy1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
